i2c_slave_rx: RTL

Write-only I2C slave receiver that sits directly downstream of the team's I2C master on the same SCL/SDA pair. Oversamples SCL/SDA on the system clock, detects START/STOP, shifts in the address byte, ACKs on address match, then receives data bytes. Each byte is presented on a parallel output with a one-cycle valid strobe. SDA ACK is driven open-drain style via an output-enable; the top level ties the pad low when sda_oe=1.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_cond.sv | 55 +++++
 rtl/i2c_slave_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, R/W encoding, default slave address
// (7'h50, i.e. the master's 8'hA0 write address byte).
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic       I2C_RW_WRITE   = 1'b0;
  localparam logic [6:0] I2C_SLAVE_ADDR = 7'h50;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } slave_state_t;

endpackage

// File: rtl/i2c_line_cond.sv
// Bus line conditioner: 2-flop synchronizer, optional glitch filter and edge detect.
// FILT_LEN = 0 bypasses the filter; otherwise the level follows only FILT_LEN agreeing samples.
module i2c_line_cond #(
  parameter int unsigned FILT_LEN = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], line_in};
  end

  if (FILT_LEN > 0) begin : g_filt
    localparam int unsigned HIST_W = (FILT_LEN > 1) ? FILT_LEN - 1 : 1;
    logic [HIST_W-1:0]   hist;
    logic [FILT_LEN-1:0] win_c;
    logic                filt;

    assign win_c = FILT_LEN'({hist, sync[1]});

    // Level moves only once the whole window agrees; shorter pulses never do.
    always_ff @(posedge clk) begin
      if (rst) begin
        hist <= '1;
        filt <= 1'b1;
      end else begin
        hist <= HIST_W'({hist, sync[1]});
        if (&win_c)       filt <= 1'b1;
        else if (~|win_c) filt <= 1'b0;
      end
    end

    assign level = filt;
  end else begin : g_direct
    assign level = sync[1];
  end

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: START/STOP detect, address match with ACK, byte receive.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert a FILT_LEN-deep glitch filter on SCL/SDA.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = I2C_SLAVE_ADDR,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       stop_seen,
  output logic       busy
);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int unsigned COND_FILT_LEN = FILT_EN ? FILT_LEN : 32'd0;

  logic scl_s, scl_rise_c, scl_fall_c;
  logic sda_s, sda_rise_c, sda_fall_c;
  logic start_c, stop_c;

  i2c_line_cond #(.FILT_LEN(COND_FILT_LEN)) u_scl (
    .clk    (clk),
    .rst    (rst),
    .line_in(scl_in),
    .level  (scl_s),
    .rise_c (scl_rise_c),
    .fall_c (scl_fall_c)
  );

  i2c_line_cond #(.FILT_LEN(COND_FILT_LEN)) u_sda (
    .clk    (clk),
    .rst    (rst),
    .line_in(sda_in),
    .level  (sda_s),
    .rise_c (sda_rise_c),
    .fall_c (sda_fall_c)
  );

  // SCL high in both samples (high now and not just risen) while SDA toggles.
  assign start_c = scl_s & ~scl_rise_c & sda_fall_c;
  assign stop_c  = scl_s & ~scl_rise_c & sda_rise_c;

  slave_state_t         state, state_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0]    shift, shift_n, shift_in_c, rx_data_n;
  logic                 sda_oe_n, rx_valid_n, addr_hit_n, stop_seen_n, busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      addr_hit  <= 1'b0;
      stop_seen <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      sda_oe    <= sda_oe_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      addr_hit  <= addr_hit_n;
      stop_seen <= stop_seen_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    rx_data_n   = rx_data;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    rx_valid_n  = 1'b0;
    addr_hit_n  = 1'b0;
    stop_seen_n = 1'b0;
    shift_in_c  = {shift[BYTE_W-2:0], sda_s};

    if (stop_c && (state != IDLE)) begin
      state_n     = IDLE;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
      stop_seen_n = 1'b1;
    end else if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b1;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise_c) begin
            shift_n   = shift_in_c;
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(7)) begin
              if (state == DATA) begin
                rx_data_n  = shift_in_c;
                rx_valid_n = 1'b1;
                state_n    = DATA_ACK;
              end else if ((shift_in_c[7:1] == SLAVE_ADDR) && (shift_in_c[0] == I2C_RW_WRITE)) begin
                addr_hit_n = 1'b1;
                state_n    = ADDR_ACK;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        // First fall ends bit 8 and starts the ACK drive; second fall ends the ACK clock.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall_c) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = DATA;
            end
          end
        end
        IGNORE:  sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

endmodule
